// File: rtl/i2s_slave_endpoint.sv
// i2s_slave_endpoint: I2S slave, 24-bit RX deserialiser and 16-bit TX serialiser
// clocked by an oversampling system clock with BCLK/LRCLK/SDIN synchronised in.
module i2s_slave_endpoint #(
  parameter int SLOT_BITS   = 32,
  parameter int RX_BITS     = 24,
  parameter int TX_BITS     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               BCLK,
  input  logic               LRCLK,
  input  logic               SDIN,
  output logic               SDOUT,
  input  logic [TX_BITS-1:0] tx_real,
  input  logic [TX_BITS-1:0] tx_imag,
  output logic               tx_load,
  output logic [RX_BITS-1:0] rx_real,
  output logic [RX_BITS-1:0] rx_imag,
  output logic               rx_valid,
  output logic               rx_error,
  output logic               locked
);
  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] RX_N   = CW'(RX_BITS);
  localparam logic [CW-1:0] SLOT_N = CW'(SLOT_BITS);
  localparam logic [CW-1:0] LAST_N = CW'(SLOT_BITS - 1);
  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sdin_sync;
  logic                   bclk_p, rise_q, fall_q, lr_q, sdin_q;
  logic                   lr_prev, started, left_ok, delay, complete;
  logic [CW-1:0]          bit_cnt;
  logic [RX_BITS-1:0]     rx_shift, left_hold;
  logic [TX_BITS-1:0]     tx_shift, tx_hold;
  // Edges are registered so the slot logic sees a one-clock pulse aligned with lr_q/sdin_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sdin_sync <= '0;
      bclk_p    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      lr_q      <= 1'b0;
      sdin_q    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], LRCLK};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], SDIN};
      bclk_p    <= bclk_sync[SYNC_STAGES-1];
      rise_q    <= bclk_sync[SYNC_STAGES-1] & ~bclk_p;
      fall_q    <= ~bclk_sync[SYNC_STAGES-1] & bclk_p;
      lr_q      <= lr_sync[SYNC_STAGES-1];
      sdin_q    <= sdin_sync[SYNC_STAGES-1];
    end
  end
  assign delay    = rise_q & started & (lr_q != lr_prev);
  assign complete = (bit_cnt >= RX_N) && (bit_cnt < SLOT_N);
  // lr_prev names the slot that is closing when a delay slot is detected.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      SDOUT     <= 1'b0;
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      rx_error  <= 1'b0;
      locked    <= 1'b0;
      rx_real   <= '0;
      rx_imag   <= '0;
      lr_prev   <= 1'b0;
      started   <= 1'b0;
      left_ok   <= 1'b0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      left_hold <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      tx_load  <= 1'b0;
      if (rise_q) begin
        started <= 1'b1;
        lr_prev <= lr_q;
        if (delay) begin
          bit_cnt  <= '0;
          locked   <= 1'b1;
          tx_shift <= lr_q ? tx_hold : tx_real;
          if (!lr_q) begin
            tx_hold <= tx_imag;
            tx_load <= 1'b1;
          end
          if (locked) begin
            // An over-long slot was already flagged when the counter saturated.
            if (bit_cnt < RX_N) rx_error <= 1'b1;
            if (!lr_prev) begin
              left_hold <= rx_shift;
              left_ok   <= complete;
            end else begin
              left_ok <= 1'b0;
              if (complete && left_ok) begin
                rx_real  <= left_hold;
                rx_imag  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end
          end
        end else begin
          if (bit_cnt != SLOT_N) bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt < RX_N) rx_shift <= {rx_shift[RX_BITS-2:0], sdin_q};
          if (locked && bit_cnt == LAST_N) rx_error <= 1'b1;
        end
      end
      if (fall_q) begin
        SDOUT    <= tx_shift[TX_BITS-1];
        tx_shift <= tx_shift << 1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_slave_endpoint.sv
// tb_i2s_slave_endpoint: drives I2S frames from a table, checks RX words through a
// scoreboard queue, SDOUT bit-by-bit, error/load pulse counts and reset behaviour.
module tb_i2s_slave_endpoint;
  localparam int SLOT = 32, RXB = 24, TXB = 16, SS = 2;
  logic clock = 1'b0, reset = 1'b0, BCLK = 1'b0, LRCLK = 1'b0, SDIN = 1'b0;
  logic SDOUT, tx_load, rx_valid, rx_error, locked;
  logic [TXB-1:0] tx_real = '0, tx_imag = '0;
  logic [RXB-1:0] rx_real, rx_imag;

  i2s_slave_endpoint #(.SLOT_BITS(SLOT), .RX_BITS(RXB), .TX_BITS(TXB), .SYNC_STAGES(SS)) dut (
    .clock(clock), .reset(reset), .BCLK(BCLK), .LRCLK(LRCLK), .SDIN(SDIN), .SDOUT(SDOUT),
    .tx_real(tx_real), .tx_imag(tx_imag), .tx_load(tx_load), .rx_real(rx_real),
    .rx_imag(rx_imag), .rx_valid(rx_valid), .rx_error(rx_error), .locked(locked));

  always #5 clock = ~clock;

  typedef struct {logic [23:0] l; logic [23:0] r;} rx_t;
  typedef struct {logic [23:0] l; logic [23:0] r; int llen; int rlen; logic [15:0] tr; logic [15:0] ti;} vec_t;
  rx_t  sb[$];
  rx_t  e;
  vec_t vecs[9];
  int   checks = 0, fails = 0, n_valid = 0, n_err = 0, n_load = 0;
  int   exp_valid = 0, exp_err = 0, nv = 0;
  time  t_edge = 0;
  logic last_lr = 1'b0, pv = 1'b0;
  logic [23:0] cur_l = '0, cur_r = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ok(input int n);
    return n >= RXB + 1 && n <= SLOT;
  endfunction

  always @(negedge clock) begin
    if (rx_valid) begin
      n_valid++;
      check("rx_valid_pulse", pv, 1'b0);
      check("rx_latency", ($time - t_edge) / 10, SS + 2);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rx_valid_unexpected: got rx_valid=1 expected 0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("rx_real", rx_real, e.l);
        check("rx_imag", rx_imag, e.r);
      end
    end
    if (rx_error) n_err++;
    if (tx_load) n_load++;
    pv = rx_valid;
  end

  // One BCLK period of 8 system clocks; SDOUT is sampled just before the next fall.
  task automatic bit_tx(input logic lr, input logic d, input logic chk, input logic exp_so);
    @(negedge clock);
    BCLK = 1'b0; LRCLK = lr; SDIN = d;
    repeat (4) @(negedge clock);
    BCLK = 1'b1;
    if (lr != last_lr && !lr) t_edge = $time;
    last_lr = lr;
    repeat (3) @(negedge clock);
    if (chk) check("sdout", SDOUT, exp_so);
  endtask

  task automatic send_slot(input logic lr, input int len, input logic [23:0] data,
                           input logic [15:0] tx, input logic chk);
    for (int k = 0; k < len; k++)
      bit_tx(lr, (k >= 1 && k <= RXB) ? data[RXB-k] : 1'($urandom_range(0, 1)), chk,
             (k >= 1 && k <= TXB) ? tx[TXB-k] : 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{24'hA5A5A5, 24'h5A5A5A, 32, 32, 16'h8001, 16'h7FFE};
    vecs[1] = '{24'h123456, 24'hABCDEF, 32, 32, 16'hFFFF, 16'h0000};
    vecs[2] = '{24'h800001, 24'h7FFFFE, 25, 25, 16'h0001, 16'h8000};
    vecs[3] = '{24'h0F0F0F, 24'hF0F0F0, 32, 20, 16'h1234, 16'h5678};
    vecs[4] = '{24'hFFFFFF, 24'h000000, 32, 32, 16'hA5A5, 16'h5A5A};
    vecs[5] = '{24'h111111, 24'h222222, 80, 32, 16'h00FF, 16'hFF00};
    vecs[6] = '{24'h333333, 24'h444444, 24, 32, 16'hC001, 16'h3FFE};
    vecs[7] = '{24'hC3C3C3, 24'h3C3C3C, 33, 32, 16'h0F0F, 16'hF0F0};
    vecs[8] = '{24'hDEADBE, 24'hEFCAFE, 32, 32, 16'hBEEF, 16'hCAFE};
    repeat (3) @(negedge clock);
    for (int i = 0; i < 6; i++) bit_tx(i[0], 1'b1, 1'b1, 1'b0);
    check("reset_outputs", {SDOUT, tx_load, rx_valid, rx_error, locked, rx_real, rx_imag}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    send_slot(1'b1, 10, 24'hFFFFFF, 16'h0000, 1'b1);
    check("unlocked", locked, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tx_real = vecs[i].tr;
      tx_imag = vecs[i].ti;
      send_slot(1'b0, vecs[i].llen, vecs[i].l, vecs[i].tr, 1'b1);
      if (i == 0) begin
        check("locked", locked, 1'b1);
        check("no_error_at_lock", n_err, 0);
      end
      check("rx_real_hold", rx_real, cur_l);
      check("rx_imag_hold", rx_imag, cur_r);
      send_slot(1'b1, vecs[i].rlen, vecs[i].r, vecs[i].ti, 1'b1);
      exp_err += int'(!ok(vecs[i].llen)) + int'(!ok(vecs[i].rlen));
      if (ok(vecs[i].llen) && ok(vecs[i].rlen)) begin
        sb.push_back('{vecs[i].l, vecs[i].r});
        cur_l = vecs[i].l;
        cur_r = vecs[i].r;
        exp_valid++;
      end
    end
    send_slot(1'b0, 32, 24'h654321, tx_real, 1'b1);
    check("rx_real_final", rx_real, cur_l);
    check("valid_count", n_valid, exp_valid);
    check("error_count", n_err, exp_err);
    check("load_count", n_load, 10);
    check("scoreboard_empty", sb.size(), 0);
    // Reset in the middle of a left word, 12 data bits in.
    send_slot(1'b1, 32, 24'h0ABCDE, 16'h0000, 1'b0);
    sb.push_back('{24'h654321, 24'h0ABCDE});
    exp_valid++;
    tx_real = 16'hFFFF;
    tx_imag = 16'h0000;
    for (int k = 0; k <= 12; k++) bit_tx(1'b0, 1'($urandom_range(0, 1)), k > 0, k > 0);
    check("valid_before_reset", n_valid, exp_valid);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_sdout", SDOUT, 1'b0);
    check("reset_rx", {rx_real, rx_imag}, 48'd0);
    check("reset_locked", locked, 1'b0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    nv = n_valid;
    send_slot(1'b0, 10, 24'hFFFFFF, 16'h0000, 1'b1);
    send_slot(1'b1, 32, 24'hFFFFFF, 16'h0000, 1'b1);
    check("relock", locked, 1'b1);
    tx_real = 16'h8001;
    tx_imag = 16'h7FFE;
    send_slot(1'b0, 32, 24'hA5A5A5, 16'h8001, 1'b1);
    check("no_valid_partial", n_valid, nv);
    send_slot(1'b1, 32, 24'h5A5A5A, 16'h7FFE, 1'b1);
    sb.push_back('{24'hA5A5A5, 24'h5A5A5A});
    send_slot(1'b0, 4, 24'h000000, 16'h8001, 1'b1);
    check("valid_after_relock", n_valid, nv + 1);
    check("error_total", n_err, exp_err);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/i2s_slave_endpoint.md
Name: i2s_slave_endpoint

Overview:
- I2S slave endpoint for the radio's audio/IQ link, i.e. the far end of the transceiver's I2S master.
- Takes BCLK/LRCLK from the master and deserialises the 24-bit RX IQ words arriving on the master's DOUT.
- Serialises 16-bit TX IQ words back onto the master's DIN.
- Used as the codec-side model in loopback builds and as the link-side core of the test fixture; everything runs in one oversampling system clock.

Parameters:
- SLOT_BITS, 32: BCLK periods per channel slot.
- RX_BITS, 24: received word width (MSB-first).
- TX_BITS, 16: transmitted word width (MSB-first, zero-padded to the slot).
- SYNC_STAGES, 2: synchroniser depth on BCLK, LRCLK and SDIN.

Ports:
- clock  in  1  system clock; must be at least 4x BCLK.
- reset  in  1  asynchronous, active-low reset.
- BCLK  in  1  bit clock from the I2S master.
- LRCLK  in  1  word select; 0 = left/real, 1 = right/imag.
- SDIN  in  1  serial data from the master (master DOUT).
- SDOUT  out  1  serial data to the master (master DIN).
- tx_real  in  TX_BITS  TX real word, sampled on tx_load.
- tx_imag  in  TX_BITS  TX imag word, sampled on tx_load.
- tx_load  out  1  one-cycle pulse: tx_real/tx_imag captured for the coming frame.
- rx_real  out  RX_BITS  last complete left word.
- rx_imag  out  RX_BITS  last complete right word.
- rx_valid  out  1  one-cycle pulse: rx_real/rx_imag updated.
- rx_error  out  1  one-cycle pulse: a slot was shorter than RX_BITS+1 bits, or longer than SLOT_BITS.
- locked  out  1  high after the first LRCLK edge is seen; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous): SDOUT, tx_load, rx_valid, rx_error and locked = 0; rx_real and rx_imag = 0; shift registers, bit counter and holding registers cleared. Reset takes effect mid-frame with no completion of the current word.
- Input sync: BCLK, LRCLK and SDIN each pass through SYNC_STAGES flops. Edges are detected on the synchronised BCLK (rise = sync high and previous low; fall likewise).
- On each BCLK rise, sample LRCLK_s and SDIN_s.
  - If LRCLK_s differs from the LRCLK sampled on the previous rise, this rise is the delay slot: bit_cnt <= 0 and the SDIN bit is discarded.
  - Otherwise bit_cnt increments, saturating at SLOT_BITS.
  - Bits with bit_cnt 1..RX_BITS shift into rx_shift MSB-first; later bits are ignored.
- Channel close, evaluated at every delay slot while locked:
  - The closing slot is complete if its final bit_cnt is between RX_BITS and SLOT_BITS-1.
  - A closing left slot, if complete, goes to left_hold.
  - A closing right slot that is complete, with a complete left_hold, drives rx_real <= left_hold, rx_imag <= rx_shift and rx_valid = 1 for exactly one clock.
  - Any incomplete slot, or bit_cnt saturating at SLOT_BITS, gives rx_error = 1 for one clock; that frame is dropped and rx_real/rx_imag keep their old values.
- locked: set at the first detected LRCLK change. Before that, nothing is emitted and there are no errors; the partial first slot is discarded silently.
- Latency: rx_valid fires in the clock after the sync'd BCLK rise that detects LRCLK 1->0, i.e. SYNC_STAGES+2 clocks after that BCLK pin edge.
- TX load: at the left delay slot (LRCLK 1->0 detected), capture tx_real and tx_imag into tx_hold and pulse tx_load for one clock. Load tx_shift with tx_hold real at the left delay slot, and with the held imag at the right delay slot.
- TX shift: on each BCLK fall after a delay slot, SDOUT <= tx_shift[MSB] and tx_shift shifts left with zero fill. After TX_BITS bits SDOUT stays 0 until the next delay slot.
- Before locked, SDOUT = 0.
- Simultaneous edges (BCLK rise and fall in the same clock) cannot occur at the required clock ratio and are not handled. If LRCLK glitches mid-slot, it is treated as a new delay slot, which produces an rx_error.

Test Plan:
- Reset held, toggle BCLK -> all outputs 0; release, 3 LRCLK periods of 64 BCLK -> locked=1 after first LRCLK edge, no rx_error.
- Master sends left=24'hA5A5A5, right=24'h5A5A5A (I2S, 1-bit delay) -> rx_valid one pulse, rx_real=A5A5A5, rx_imag=5A5A5A; rx_valid pulses every 64 BCLK thereafter.
- tx_real=16'h8001, tx_imag=16'h7FFE -> tx_load pulses at left delay slot; SDOUT bits 1..16 of the left slot = 8001 MSB-first, bits 17..31 = 0; right slot = 7FFE.
- Shorten one right slot to 20 BCLK -> rx_error one pulse, no rx_valid that frame, rx_real/rx_imag unchanged; next full frame -> rx_valid.
- Assert reset mid-word (bit_cnt=12) -> SDOUT=0 immediately, rx_real=0; after release, first rx_valid only after locked and a full frame.
- Hold LRCLK constant 80 BCLK -> rx_error once at saturation, no rx_valid.
